// File: rtl/monster_swarm_ctrl_pkg.sv
// Shared types and defaults for the monster swarm: stage index, screen coordinate,
// per-stage monster amounts, the swarm state encoding and a popcount helper.
package monster_swarm_ctrl_pkg;

    localparam int MONSTERS_MAX    = 16;
    localparam int MONSTERS_STAGES = 5;
    localparam int MONSTERS_IDX_W  = $clog2(MONSTERS_MAX);

    typedef logic [2:0]         game_stage;
    typedef logic signed [10:0] coordinate;

    // Entry n is the amount for stage n: {0, 8, 16, 0, 12}.
    localparam logic [MONSTERS_STAGES-1:0][MONSTERS_IDX_W:0] MONSTERS_PER_STAGE_DEF =
        {5'd12, 5'd0, 5'd16, 5'd8, 5'd0};

    typedef enum logic [1:0] {
        SWARM_IDLE    = 2'd0,
        SWARM_SPAWN   = 2'd1,
        SWARM_ACTIVE  = 2'd2,
        SWARM_CLEARED = 2'd3
    } swarm_state_t;

    localparam int POP_W = 64;

    function automatic logic [6:0] popcount(input logic [POP_W-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < POP_W; i++) c = c + 7'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/monster_swarm_ctrl_priority_select.sv
// Lowest-index encoder over a request vector, with an any-request flag and a
// flag for two or more simultaneous requests.
module priority_select #(
    parameter int N = 16,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] index,
    output logic             overlap
);

    always_comb begin
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) index = IDX_W'(i);
        end
    end

    assign found = |req;
    // Clearing the lowest set bit leaves something only if a second bit was set.
    assign overlap = |(req & (req - 1'b1));

endmodule

// File: rtl/monster_swarm_ctrl.sv
// Swarm controller: wave-based release of monsters per stage, per-pixel owner
// selection, and serialisation of simultaneous deaths into single kill pulses.
module monster_swarm_ctrl
    import monster_swarm_ctrl_pkg::*;
#(
    parameter int MAX_MONSTERS = MONSTERS_MAX,
    parameter int STAGE_COUNT = MONSTERS_STAGES,
    parameter logic [STAGE_COUNT-1:0][$clog2(MAX_MONSTERS):0] MONSTERS_PER_STAGE = MONSTERS_PER_STAGE_DEF,
    parameter int WAVE_SIZE = 4,
    parameter int SPAWN_INTERVAL = 30,
    parameter int KILL_W = 8,
    localparam int IDX_W = $clog2(MAX_MONSTERS)
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    enable,
    input  logic                    startOfFrame,
    input  game_stage               stage_num,
    input  logic [MAX_MONSTERS-1:0] silhouetteDR,
    input  logic [MAX_MONSTERS-1:0] monster_hit,
    input  logic [MAX_MONSTERS-1:0] monster_exploded,
    output logic [MAX_MONSTERS-1:0] monster_active,
    output logic                    any_DR,
    output logic [IDX_W-1:0]        chosen_index,
    output logic                    overlap,
    output logic                    kill_pulse,
    output logic [KILL_W-1:0]       kill_count,
    output logic                    all_monsters_dead,
    output logic [1:0]              swarm_state
);

    localparam int CNT_W = IDX_W + 1;
    localparam int FC_W  = $clog2(SPAWN_INTERVAL + 1);
    localparam int PEND_MAX = (1 << CNT_W) - 1;

    swarm_state_t            state, state_nx;
    game_stage               stage_reg;
    logic [CNT_W-1:0]        amount, released, released_nx;
    logic [FC_W-1:0]         frame_cnt, frame_cnt_nx;
    logic [MAX_MONSTERS-1:0] active_nx, prev_hit, live, req, rise;
    logic [CNT_W-1:0]        pending, pending_nx;
    logic                    kill_pulse_nx, stage_change, wave;
    int                      pend_sum;

    // Bits [n-1:0] set.
    function automatic logic [MAX_MONSTERS-1:0] below(input logic [CNT_W-1:0] n);
        logic [MAX_MONSTERS-1:0] m;
        for (int i = 0; i < MAX_MONSTERS; i++) m[i] = (i < int'(n));
        return m;
    endfunction

    always_comb begin
        amount = '0;
        if (int'(stage_num) < STAGE_COUNT) amount = MONSTERS_PER_STAGE[stage_num];
    end

    assign stage_change = (stage_reg != stage_num);

    always_comb begin
        state_nx     = state;
        released_nx  = released;
        frame_cnt_nx = frame_cnt;
        active_nx    = monster_active;
        wave         = 1'b0;
        case (state)
            SWARM_IDLE: if (amount != '0) state_nx = SWARM_SPAWN;
            SWARM_SPAWN: begin
                if (startOfFrame && enable) begin
                    wave = (frame_cnt == '0);
                    frame_cnt_nx = (frame_cnt == FC_W'(SPAWN_INTERVAL - 1)) ? '0 : frame_cnt + 1'b1;
                end
                if (wave) begin
                    released_nx = (int'(released) + WAVE_SIZE >= int'(amount)) ?
                                  amount : released + CNT_W'(WAVE_SIZE);
                    active_nx = monster_active | (below(released_nx) & ~below(released));
                end
                if (released_nx == amount) state_nx = SWARM_ACTIVE;
            end
            SWARM_ACTIVE:
                if (&(monster_exploded | ~below(amount))) state_nx = SWARM_CLEARED;
            default: ;
        endcase
    end

    // Pending counts deaths not yet pulsed, including the pulse now on the output.
    always_comb begin
        rise     = monster_hit & ~prev_hit & monster_active;
        pend_sum = int'(pending) + int'(popcount(POP_W'(rise))) - int'(kill_pulse);
        if (pend_sum > PEND_MAX)  pending_nx = '1;
        else if (pend_sum < 0)    pending_nx = '0;
        else                      pending_nx = CNT_W'(pend_sum);
        kill_pulse_nx = (pending_nx != '0);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= SWARM_IDLE;
            stage_reg      <= '0;
            released       <= '0;
            frame_cnt      <= '0;
            monster_active <= '0;
            prev_hit       <= '0;
            pending        <= '0;
            kill_pulse     <= 1'b0;
            kill_count     <= '0;
        end else if (stage_change) begin
            state          <= SWARM_IDLE;
            stage_reg      <= stage_num;
            released       <= '0;
            frame_cnt      <= '0;
            monster_active <= '0;
            prev_hit       <= '0;
            pending        <= '0;
            kill_pulse     <= 1'b0;
            kill_count     <= '0;
        end else begin
            state          <= state_nx;
            released       <= released_nx;
            frame_cnt      <= frame_cnt_nx;
            monster_active <= active_nx;
            prev_hit       <= monster_hit;
            pending        <= pending_nx;
            kill_pulse     <= kill_pulse_nx;
            if (kill_pulse && (kill_count != '1)) kill_count <= kill_count + 1'b1;
        end
    end

    assign live = monster_active & ~monster_exploded;
    assign req  = silhouetteDR & live;

    priority_select #(.N(MAX_MONSTERS)) u_select (
        .req     (req),
        .found   (any_DR),
        .index   (chosen_index),
        .overlap (overlap)
    );

    assign all_monsters_dead = (state == SWARM_CLEARED);
    assign swarm_state       = state;

endmodule

// File: doc/monster_swarm_ctrl.md
# monster_swarm_ctrl

Parametrised controller for a group of up to MAX_MONSTERS monster instances. It releases monsters into play in timed waves per stage, picks the single monster that owns each pixel, and detects overlap. It serialises simultaneous deaths into one kill pulse each and keeps a stage kill count. It sits between the stage logic and the generated monster instances, alongside the chicken bitmap that consumes the chosen index.

## Interface
Parameters:
- MAX_MONSTERS, 16: number of monster instances served; IDX_W = $clog2(MAX_MONSTERS).
- STAGE_COUNT, 5: number of stage table entries.
- MONSTERS_PER_STAGE, {0,8,16,0,12}: per-stage monster amount, STAGE_COUNT entries of IDX_W+1 bits; index = stage_num.
- WAVE_SIZE, 4: monsters released per wave.
- SPAWN_INTERVAL, 30: frames between waves, ≥1.
- KILL_W, 8: kill counter width.

Ports:
- clk  in  1  clock.
- resetN  in  1  reset, asynchronous, active-low.
- enable  in  1  game running; gates wave timing only.
- startOfFrame  in  1  one-cycle frame pulse.
- stage_num  in  game_stage  current stage.
- silhouetteDR  in  MAX_MONSTERS  per-monster rectangle draw request.
- monster_hit  in  MAX_MONSTERS  per-monster hit level (sticky until the instance resets).
- monster_exploded  in  MAX_MONSTERS  per-monster explosion finished.
- monster_active  out  MAX_MONSTERS  monster released and inside amount; ANDed into each instance's startOfFrame.
- any_DR  out  1  some live monster requests this pixel.
- chosen_index  out  IDX_W  lowest-index live requester; 0 when none.
- overlap  out  1  ≥2 live monsters request this pixel.
- kill_pulse  out  1  one-cycle pulse per death.
- kill_count  out  KILL_W  deaths this stage, saturating.
- all_monsters_dead  out  1  stage cleared.
- swarm_state  out  2  IDLE=0, SPAWN=1, ACTIVE=2, CLEARED=3.

## Operation
- amount = MONSTERS_PER_STAGE[stage_num]. A monster is live when monster_active[i] & !monster_exploded[i].
- FSM:
  - IDLE → SPAWN on any cycle with amount≠0.
  - SPAWN: on each startOfFrame & enable, frame_cnt increments. A wave is released when frame_cnt==0 (the first frame) and then every SPAWN_INTERVAL frames.
  - A wave sets active bits [released, min(released+WAVE_SIZE, amount)−1], then released += WAVE_SIZE, saturating at amount.
  - SPAWN → ACTIVE when released == amount.
  - ACTIVE → CLEARED when every i<amount has monster_exploded[i]=1.
  - CLEARED holds until a stage change.
- Stage change: a registered stage_num differing from the input forces, on the next edge: state=IDLE, monster_active=0, released=0, frame_cnt=0, kill_count=0, pending=0, prev_hit=0. Any SPAWN in progress is abandoned.
- amount==0: FSM stays IDLE, all_monsters_dead=0.
- Pixel arbitration (combinational):
  - any_DR = |(silhouetteDR & live).
  - chosen_index = lowest set bit of (silhouetteDR & live).
  - overlap = popcount ≥ 2.
- Kill serialisation:
  - rise = monster_hit & ~prev_hit & monster_active.
  - pending (IDX_W+1 bits) += popcount(rise) − (kill_pulse this cycle), saturating.
  - kill_pulse is asserted for one cycle whenever pending>0. It is registered, so back-to-back pulses are allowed.
  - kill_count increments on each kill_pulse and saturates at all ones.
- all_monsters_dead = (state==CLEARED).

## Timing
- Reset values: all outputs 0; state IDLE; internal counters 0.
- monster_active bits change the cycle after the releasing startOfFrame edge.
- First kill_pulse comes 1 cycle after the hit rise is sampled (the rise is registered into pending, then pulse). k simultaneous hits produce k pulses on k consecutive cycles.
- all_monsters_dead rises 1 cycle after the last monster_exploded rises.
- Stage change clears state 1 cycle after stage_num changes. A hit rise in that same cycle is discarded.
- enable low: SPAWN frame_cnt freezes. Arbitration and kill logic keep running.
- Arbitration outputs have zero latency; an external pixel pipeline must align.

## Structure
- Shared package holds game_stage, coordinate, the MONSTERS_* defaults and the swarm_state enum.
- Sub-module priority_select (parametric lowest-index encoder plus overlap flag) is instantiated once and is reusable for the missile pool.
- Popcount is a function in the package.

## Test plan
- Stage 1 (amount 8, WAVE 4, INTERVAL 30): monster_active goes 0x0F after frame 0 and 0xFF after frame 30. swarm_state becomes ACTIVE in the cycle after frame 30.
- Hit rises on monsters 2, 5, 7 in one cycle → kill_pulse high on 3 consecutive cycles starting 1 cycle later; kill_count=3.
- silhouetteDR=0x0C with both live → chosen_index=2, overlap=1. Monster 2 exploded → chosen_index=3, overlap=0.
- All 8 exploded → all_monsters_dead=1 one cycle after the last one; stage_num→2 → all outputs 0 the next cycle, then SPAWN restarts.
- Stage 3 (amount 0) → state stays IDLE and all_monsters_dead stays 0 for 100 frames.
- resetN asserted mid-SPAWN → outputs 0 asynchronously. After release, wave 0 comes on the next enabled startOfFrame.
